seq_arb_ctrl: RTL and testbench

Parametrised multi-channel sequential controller, the successor to the team's fixed 5-flop benchmark controllers. It arbitrates CH request lines round-robin and runs the granted job through a CNT_W-bit down-counter. It pulses a per-channel completion flag at the end of each job. With the scan option enabled it exposes one full scan chain over every state flop, so ATPG flows can exercise it both as a sequential benchmark and as a full-scan benchmark.

---
 rtl/seq_arb_ctrl_if.sv | 35 +++
 rtl/seq_arb_ctrl.sv | 145 ++++++++++++++
 tb/tb_seq_arb_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/seq_arb_ctrl_if.sv
// -----------------------------------------------------------------------------
// seq_arb_ctrl_if
// Request/grant bundle between a requesting environment and seq_arb_ctrl.
//   REQ   [CH]        per-channel request level      (master -> slave)
//   LEN   [CH*CNT_W]  per-channel job length         (master -> slave)
//   HOLD              freeze counting / arbitration  (master -> slave)
//   GNT   [CH]        one-hot grant, high in RUN     (slave -> master)
//   DONE  [CH]        one-hot completion pulse       (slave -> master)
//   BUSY              high in RUN or DONE            (slave -> master)
//   CNT   [CNT_W]     remaining count                (slave -> master)
//   STATE [2]         FSM state IDLE=00 RUN=01 DONE=10 (slave -> master)
// -----------------------------------------------------------------------------
interface seq_arb_ctrl_if #(
    parameter int CH    = 4,
    parameter int CNT_W = 8
);
    logic [CH-1:0]       REQ;
    logic [CH*CNT_W-1:0] LEN;
    logic                HOLD;
    logic [CH-1:0]       GNT;
    logic [CH-1:0]       DONE;
    logic                BUSY;
    logic [CNT_W-1:0]    CNT;
    logic [1:0]          STATE;

    modport master (
        output REQ, LEN, HOLD,
        input  GNT, DONE, BUSY, CNT, STATE
    );

    modport slave (
        input  REQ, LEN, HOLD,
        output GNT, DONE, BUSY, CNT, STATE
    );
endinterface

// File: rtl/seq_arb_ctrl.sv
// -----------------------------------------------------------------------------
// seq_arb_ctrl
// Round-robin arbiter over CH request lines driving a CNT_W-bit job
// down-counter, with a one-cycle per-channel completion pulse.
//
// Ports:
//   CK    clock, rising edge
//   RST   synchronous active-high reset (highest priority)
//   bus   seq_arb_ctrl_if.slave (REQ/LEN/HOLD in, GNT/DONE/BUSY/CNT/STATE out)
//   SE/SI/SO  scan enable, scan in, scan out -- present only with SCAN_EN
//
// Optional feature macro: SCAN_EN. When defined, SE=1 (and RST=0) turns all
// state flops into one shift chain SI -> st -> cur -> ptr -> cnt -> SO.
// All outputs are decoded from flops only.
// -----------------------------------------------------------------------------
module seq_arb_ctrl #(
    parameter int CH    = 4,
    parameter int CNT_W = 8
) (
    input  logic          CK,
    input  logic          RST,
    seq_arb_ctrl_if.slave bus
`ifdef SCAN_EN
    ,
    input  logic          SE,
    input  logic          SI,
    output logic          SO
`endif
);
    localparam int IW = $clog2(CH);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10,
        S_BAD  = 2'b11
    } state_t;

    state_t           st_reg,  st_next;
    logic [IW-1:0]    cur_reg, cur_next;
    logic [IW-1:0]    ptr_reg, ptr_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    // Round-robin search starting at ptr. Iterating downward means the
    // smallest offset from ptr is the last to write, so it wins.
    logic          arb_found;
    logic [IW-1:0] arb_sel;
    logic [IW:0]   arb_idx;

    always_comb begin
        arb_found = 1'b0;
        arb_sel   = '0;
        arb_idx   = '0;
        for (int k = CH - 1; k >= 0; k--) begin
            arb_idx = {1'b0, ptr_reg} + (IW+1)'(k);
            // ptr may exceed CH-1 only after a scan load, so two folds cover it
            if (arb_idx >= (IW+1)'(CH)) arb_idx = arb_idx - (IW+1)'(CH);
            if (arb_idx >= (IW+1)'(CH)) arb_idx = arb_idx - (IW+1)'(CH);
            if (bus.REQ[arb_idx[IW-1:0]]) begin
                arb_found = 1'b1;
                arb_sel   = arb_idx[IW-1:0];
            end
        end
    end

    // Next-state logic
    always_comb begin
        st_next  = st_reg;
        cur_next = cur_reg;
        ptr_next = ptr_reg;
        cnt_next = cnt_reg;
        case (st_reg)
            S_IDLE: begin
                if (!bus.HOLD && arb_found) begin
                    cur_next = arb_sel;
                    cnt_next = bus.LEN[int'(arb_sel) * CNT_W +: CNT_W];
                    st_next  = S_RUN;
                end
            end
            S_RUN: begin
                if (!bus.HOLD) begin
                    if (cnt_reg == CNT_W'(1)) begin
                        st_next = S_DONE;
                    end else begin
                        // LEN=0 wraps through all-ones, giving 2^CNT_W cycles
                        cnt_next = cnt_reg - CNT_W'(1);
                    end
                end
            end
            S_DONE: begin
                if ({1'b0, cur_reg} >= (IW+1)'(CH - 1)) begin
                    ptr_next = '0;
                end else begin
                    ptr_next = cur_reg + IW'(1);
                end
                cnt_next = '0;
                st_next  = S_IDLE;
            end
            default: begin
                cnt_next = '0;
                st_next  = S_IDLE;
            end
        endcase
    end

`ifdef SCAN_EN
    localparam int CL = 2 + 2 * IW + CNT_W;
    logic [CL-1:0] chain;
    logic [CL-1:0] chain_next;
    // Bit 0 is st[0], the first flop after SI; the MSB is cnt[CNT_W-1].
    assign chain      = {cnt_reg, ptr_reg, cur_reg, st_reg};
    assign chain_next = {chain[CL-2:0], SI};
    assign SO         = chain[CL-1];
`endif

    always_ff @(posedge CK) begin
        if (RST) begin
            st_reg  <= S_IDLE;
            cur_reg <= '0;
            ptr_reg <= '0;
            cnt_reg <= '0;
`ifdef SCAN_EN
        end else if (SE) begin
            st_reg  <= state_t'(chain_next[1:0]);
            cur_reg <= chain_next[2 +: IW];
            ptr_reg <= chain_next[2 + IW +: IW];
            cnt_reg <= chain_next[2 + 2 * IW +: CNT_W];
`endif
        end else begin
            st_reg  <= st_next;
            cur_reg <= cur_next;
            ptr_reg <= ptr_next;
            cnt_reg <= cnt_next;
        end
    end

    logic [CH-1:0] cur_onehot;
    assign cur_onehot = {{(CH-1){1'b0}}, 1'b1} << cur_reg;

    assign bus.GNT   = (st_reg == S_RUN)  ? cur_onehot : '0;
    assign bus.DONE  = (st_reg == S_DONE) ? cur_onehot : '0;
    assign bus.BUSY  = (st_reg == S_RUN) || (st_reg == S_DONE);
    assign bus.CNT   = cnt_reg;
    assign bus.STATE = st_reg;
endmodule

// File: tb/tb_seq_arb_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seq_arb_ctrl
// Directed bench for seq_arb_ctrl with CH=4, CNT_W=8. Inputs are driven and
// outputs sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_seq_arb_ctrl;
    localparam int CH    = 4;
    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic rst;
    int   err_cnt = 0;
    int   chk_cnt = 0;

    always #5 clk = ~clk;

    seq_arb_ctrl_if #(.CH(CH), .CNT_W(CNT_W)) bus ();

`ifdef SCAN_EN
    logic se, si, so;
`endif

    seq_arb_ctrl #(.CH(CH), .CNT_W(CNT_W)) dut (
        .CK  (clk),
        .RST (rst),
        .bus (bus.slave)
`ifdef SCAN_EN
        ,
        .SE  (se),
        .SI  (si),
        .SO  (so)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        bus.REQ  = '0;
        bus.LEN  = '0;
        bus.HOLD = 1'b0;
`ifdef SCAN_EN
        se = 1'b0;
        si = 1'b0;
`endif
        tick();
        tick();
        check("rst_state", 32'(bus.STATE), 32'h0);
        check("rst_gnt",   32'(bus.GNT),   32'h0);
        check("rst_done",  32'(bus.DONE),  32'h0);
        check("rst_busy",  32'(bus.BUSY),  32'h0);
        check("rst_cnt",   32'(bus.CNT),   32'h0);
        rst = 1'b0;

        // Reset held 2 cycles in the middle of a job on channel 1
        bus.REQ        = 4'b0010;
        bus.LEN[15:8]  = 8'd10;
        tick();
        check("job1_gnt", 32'(bus.GNT), 32'h2);
        tick();
        rst = 1'b1;
        tick();
        tick();
        check("abort_state", 32'(bus.STATE), 32'h0);
        check("abort_gnt",   32'(bus.GNT),   32'h0);
        check("abort_done",  32'(bus.DONE),  32'h0);
        check("abort_busy",  32'(bus.BUSY),  32'h0);
        check("abort_cnt",   32'(bus.CNT),   32'h0);
        rst     = 1'b0;
        bus.REQ = '0;
        tick();
        check("abort_nodone", 32'(bus.DONE), 32'h0);

        // Single job on channel 0, LEN=3
        bus.LEN[7:0] = 8'd3;
        bus.REQ      = 4'b0001;
        tick();
        check("single_gnt",   32'(bus.GNT),   32'h1);
        check("single_cnt3",  32'(bus.CNT),   32'd3);
        check("single_busy",  32'(bus.BUSY),  32'h1);
        check("single_state", 32'(bus.STATE), 32'h1);
        bus.REQ = '0;
        tick();
        check("single_cnt2", 32'(bus.CNT), 32'd2);
        tick();
        check("single_cnt1", 32'(bus.CNT), 32'd1);
        tick();
        check("single_done",   32'(bus.DONE),  32'h1);
        check("single_dstate", 32'(bus.STATE), 32'h2);
        check("single_dgnt",   32'(bus.GNT),   32'h0);
        tick();
        check("single_idle",  32'(bus.STATE), 32'h0);
        check("single_ibusy", 32'(bus.BUSY),  32'h0);
        check("single_icnt",  32'(bus.CNT),   32'h0);

        // Fairness: pointer back to 0, all channels request, LEN=1 each
        rst = 1'b1;
        tick();
        rst     = 1'b0;
        bus.LEN = 32'h01010101;
        bus.REQ = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("fair_gnt%0d", i), 32'(bus.GNT), 32'(1 << (i % 4)));
            if (i < 4) begin
                tick();
                check($sformatf("fair_done%0d", i), 32'(bus.DONE), 32'(1 << i));
                tick();
                check($sformatf("fair_idle%0d", i), 32'(bus.STATE), 32'h0);
            end
        end
        bus.REQ = '0;
        tick();
        tick();

        // Wrap and hold: LEN=0 on channel 0 runs 256 cycles
        bus.LEN  = '0;
        bus.REQ  = 4'b0001;
        bus.HOLD = 1'b1;
        tick();
        check("hold_idle", 32'(bus.STATE), 32'h0);
        bus.HOLD = 1'b0;
        tick();
        check("wrap_gnt",  32'(bus.GNT), 32'h1);
        check("wrap_cnt0", 32'(bus.CNT), 32'd0);
        bus.REQ = '0;
        tick();
        check("wrap_cnt255", 32'(bus.CNT), 32'd255);
        repeat (251) tick();
        check("wrap_cnt4", 32'(bus.CNT), 32'd4);
        bus.HOLD = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("hold_cnt%0d", i), 32'(bus.CNT), 32'd4);
        end
        bus.HOLD = 1'b0;
        tick();
        check("rel_cnt3", 32'(bus.CNT), 32'd3);
        tick();
        tick();
        check("rel_cnt1", 32'(bus.CNT), 32'd1);
        check("rel_run",  32'(bus.STATE), 32'h1);
        tick();
        check("rel_done", 32'(bus.DONE), 32'h1);
        tick();

        // Abort on channel 2 at CNT=2, then pointer restarts at 0
        bus.LEN[23:16] = 8'd5;
        bus.REQ        = 4'b0100;
        tick();
        check("ab2_gnt", 32'(bus.GNT), 32'h4);
        check("ab2_cnt", 32'(bus.CNT), 32'd5);
        bus.REQ = '0;
        repeat (3) tick();
        check("ab2_cnt2", 32'(bus.CNT), 32'd2);
        rst     = 1'b1;
        bus.REQ = 4'b0101;
        tick();
        check("ab2_state", 32'(bus.STATE), 32'h0);
        check("ab2_done",  32'(bus.DONE),  32'h0);
        check("ab2_cnt",   32'(bus.CNT),   32'h0);
        rst = 1'b0;
        tick();
        check("ab2_regnt", 32'(bus.GNT), 32'h1);
        bus.REQ = '0;

`ifdef SCAN_EN
        begin
            logic [13:0] pat;
            logic [13:0] ld;
            pat = 14'h2D5A;
            ld  = {8'd1, 2'b00, 2'b00, 2'b01};
            se  = 1'b1;
            for (int j = 0; j < 14; j++) begin
                si = pat[j];
                tick();
            end
            for (int k = 0; k < 14; k++) begin
                check($sformatf("scan_so%0d", k), 32'(so), 32'(pat[k]));
                si = 1'b0;
                tick();
            end
            for (int j = 13; j >= 0; j--) begin
                si = ld[j];
                tick();
            end
            se = 1'b0;
            check("scan_ld_state", 32'(bus.STATE), 32'h1);
            check("scan_ld_cnt",   32'(bus.CNT),   32'h1);
            tick();
            check("scan_done", 32'(bus.DONE), 32'h1);
        end
`endif

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
